// File: rtl/bus_arbiter_param.sv
// Serial-address bus arbiter. Picks one of NUM_MASTERS requesters (fixed or
// round-robin), shifts in its slave address MSB first, then holds one-hot
// master/slave grants until the owner lets go, the address is bad, or the
// watchdog fires. Every release passes through a one-cycle RELEASE bubble.
module bus_arbiter_param #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3,
  parameter int SEL_W       = 2,
  parameter int RR_MODE     = 1,
  parameter int TIMEOUT     = 4096,
  parameter int MIDX_W      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] m_request,
  input  logic                   slave_select,
  output logic [NUM_MASTERS-1:0] m_grant,
  output logic [MIDX_W-1:0]      bus_grant,
  output logic [NUM_SLAVES-1:0]  slave_grant,
  output logic                   busy,
  output logic                   err_slave,
  output logic                   timeout
);
  // Watchdog only has to reach TIMEOUT-1, so it can never wrap.
  localparam int WD_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int WD_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int BC_W    = (SEL_W > 1) ? $clog2(SEL_W) : 1;

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_SEL, S_CONN, S_REL} state_t;

  state_t                  state_q;
  logic [MIDX_W-1:0]       own_q, last_q, bus_grant_q;
  logic [SEL_W-1:0]        addr_q, addr_d;
  logic [BC_W-1:0]         bcnt_q;
  logic [WD_W-1:0]         wd_q;
  logic [NUM_MASTERS-1:0]  m_grant_q;
  logic [NUM_SLAVES-1:0]   slave_grant_q;
  logic                    busy_q, err_q, tmo_q;

  logic [MIDX_W-1:0]       start_idx, win_idx;
  logic [MIDX_W:0]         cand;
  logic                    win_vld;
  logic                    own_req, addr_ok, last_bit, wd_exp;
  logic                    rel_d, err_d, tmo_d;

  // Arbitration: scan from the RR pointer (or index 0) and take the first requester.
  always_comb begin
    start_idx = '0;
    if (RR_MODE != 0 && last_q != MIDX_W'(NUM_MASTERS - 1))
      start_idx = last_q + 1'b1;
    win_idx = '0;
    win_vld = 1'b0;
    cand    = '0;
    // Walk backwards so the candidate closest to start_idx is the last one written.
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      cand = {1'b0, start_idx} + (MIDX_W+1)'(k);
      if (cand >= (MIDX_W+1)'(NUM_MASTERS))
        cand = cand - (MIDX_W+1)'(NUM_MASTERS);
      if (m_request[cand[MIDX_W-1:0]]) begin
        win_idx = cand[MIDX_W-1:0];
        win_vld = 1'b1;
      end
    end
  end

  // Exit conditions; an owner drop outranks both a bad address and a timeout.
  always_comb begin
    own_req  = m_request[own_q];
    addr_d   = SEL_W'({addr_q, slave_select});
    addr_ok  = ({1'b0, addr_d} < (SEL_W+1)'(NUM_SLAVES));
    last_bit = (bcnt_q == BC_W'(SEL_W - 1));
    wd_exp   = (TIMEOUT != 0) && (wd_q == WD_W'(WD_LAST));
    rel_d    = 1'b0;
    err_d    = 1'b0;
    tmo_d    = 1'b0;
    case (state_q)
      S_GRANT: rel_d = !own_req;
      S_SEL: begin
        rel_d = !own_req || (last_bit && !addr_ok);
        err_d = own_req && last_bit && !addr_ok;
      end
      S_CONN: begin
        rel_d = !own_req || wd_exp;
        tmo_d = own_req && wd_exp;
      end
      default: ;
    endcase
  end

  // Transaction FSM with registered grant/status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      own_q         <= '0;
      last_q        <= MIDX_W'(NUM_MASTERS - 1);
      addr_q        <= '0;
      bcnt_q        <= '0;
      wd_q          <= '0;
      m_grant_q     <= '0;
      bus_grant_q   <= '0;
      slave_grant_q <= '0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      tmo_q         <= 1'b0;
    end else begin
      err_q <= err_d;
      tmo_q <= tmo_d;
      if (rel_d) begin
        m_grant_q     <= '0;
        bus_grant_q   <= '0;
        slave_grant_q <= '0;
        busy_q        <= 1'b0;
        state_q       <= S_REL;
      end else begin
        case (state_q)
          S_IDLE: if (win_vld) begin
            own_q       <= win_idx;
            m_grant_q   <= NUM_MASTERS'(1) << win_idx;
            bus_grant_q <= win_idx;
            busy_q      <= 1'b1;
            addr_q      <= '0;
            state_q     <= S_GRANT;
          end
          S_GRANT: state_q <= S_SEL;
          S_SEL: begin
            addr_q <= addr_d;
            if (last_bit) begin
              slave_grant_q <= NUM_SLAVES'(1) << addr_d;
              state_q       <= S_CONN;
            end else begin
              bcnt_q <= bcnt_q + 1'b1;
            end
          end
          S_CONN: if (TIMEOUT != 0) wd_q <= wd_q + 1'b1;
          S_REL: begin
            last_q  <= own_q;
            wd_q    <= '0;
            bcnt_q  <= '0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign m_grant     = m_grant_q;
  assign bus_grant   = bus_grant_q;
  assign slave_grant = slave_grant_q;
  assign busy        = busy_q;
  assign err_slave   = err_q;
  assign timeout     = tmo_q;
endmodule
